// File: rtl/photodiode_link_tx_if.sv
// Payload handshake between a byte source and the photodiode link transmitter.
// The requested drive level travels with the byte and is latched on the same edge.
interface photodiode_link_tx_if;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] drive_level;

  modport master (output tx_data, output tx_valid, output drive_level, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input drive_level, output tx_ready);
endinterface

// File: rtl/photodiode_link_tx.sv
// Optical link transmitter: frames a byte as preamble/data/parity/guard symbols
// on a laser, clips the drive code and aborts into a sticky FAULT on interlock loss.
module photodiode_link_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DRIVE_MAX_MV = 4500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  photodiode_link_tx_if.slave     tx,
  input  logic                    interlock_ok,
  input  logic                    fault_clr,
  output logic                    laser_on,
  output logic [15:0]             drive_code,
  output logic                    busy,
  output logic                    fault,
  output logic                    frame_done
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_DATA     = 3'd2;
  localparam logic [2:0] ST_PARITY   = 3'd3;
  localparam logic [2:0] ST_GUARD    = 3'd4;
  localparam logic [2:0] ST_FAULT    = 3'd5;

  localparam logic [7:0]  BIT_LAST  = 8'(CLKS_PER_BIT - 1);
  localparam logic [15:0] DRIVE_MAX = 16'(DRIVE_MAX_MV);

  logic [2:0]  state_q, state_d;
  logic [7:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  sym_cnt_q, sym_cnt_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] level_q, level_d;
  logic        done_d;
  logic        sym_d;
  logic [15:0] code_d;

  assign tx.tx_ready = (state_q == ST_IDLE) && interlock_ok && rst_n;
  assign busy        = state_q inside {ST_PREAMBLE, ST_DATA, ST_PARITY, ST_GUARD};
  assign fault       = (state_q == ST_FAULT);

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sym_cnt_d = sym_cnt_q;
    data_d    = data_q;
    level_d   = level_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (tx.tx_valid && tx.tx_ready) begin
          state_d   = ST_PREAMBLE;
          bit_cnt_d = '0;
          sym_cnt_d = '0;
          data_d    = tx.tx_data;
          level_d   = tx.drive_level;
        end
      end
      ST_PREAMBLE, ST_DATA, ST_PARITY, ST_GUARD: begin
        if (!interlock_ok) begin
          state_d   = ST_FAULT;
          bit_cnt_d = '0;
          sym_cnt_d = '0;
        end else if (bit_cnt_q != BIT_LAST) begin
          bit_cnt_d = bit_cnt_q + 8'd1;
        end else begin
          // Symbol boundary: step the symbol counter, wrapping it at each phase change.
          bit_cnt_d = '0;
          sym_cnt_d = sym_cnt_q + 3'd1;
          unique case (state_q)
            ST_PREAMBLE: if (sym_cnt_q == 3'd3) begin state_d = ST_DATA;   sym_cnt_d = '0; end
            ST_DATA:     if (sym_cnt_q == 3'd7) begin state_d = ST_PARITY; sym_cnt_d = '0; end
            ST_PARITY:   begin state_d = ST_GUARD; sym_cnt_d = '0; end
            default:     begin state_d = ST_IDLE;  sym_cnt_d = '0; done_d = 1'b1; end
          endcase
        end
      end
      ST_FAULT: begin
        if (fault_clr && interlock_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Symbol is derived from the next state so the laser tracks the state with no lag.
    unique case (state_d)
      ST_PREAMBLE: sym_d = ~sym_cnt_d[0];
      ST_DATA:     sym_d = data_d[3'd7 - sym_cnt_d];
      ST_PARITY:   sym_d = ^data_d;
      default:     sym_d = 1'b0;
    endcase

    code_d = '0;
    if (sym_d) code_d = (level_d > DRIVE_MAX) ? DRIVE_MAX : level_d;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: latched byte and level are cleared too, so no stale payload survives a reset.
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      sym_cnt_q  <= '0;
      data_q     <= '0;
      level_q    <= '0;
      laser_on   <= 1'b0;
      drive_code <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sym_cnt_q  <= sym_cnt_d;
      data_q     <= data_d;
      level_q    <= level_d;
      laser_on   <= sym_d;
      drive_code <= code_d;
      frame_done <= done_d;
    end
  end

endmodule

// File: doc/photodiode_link_tx.md
PHOTODIODE_LINK_TX -- requirements
Module: photodiode_link_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles per transmitted symbol (legal range 1..255).
REQ-002 Parameter DRIVE_MAX_MV, default 4500, upper clip on the laser drive code in mV.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 tx_data  input  8  payload byte to transmit.
REQ-006 tx_valid  input  1  payload offered.
REQ-007 tx_ready  output  1  block can accept a byte this cycle.
REQ-008 drive_level  input  16  requested laser drive in mV, sampled with the payload.
REQ-009 interlock_ok  input  1  eye-safety interlock; 1 = emission permitted.
REQ-010 fault_clr  input  1  single-cycle request to leave FAULT.
REQ-011 laser_on  output  1  registered optical symbol (1 = emit).
REQ-012 drive_code  output  16  registered DAC code in mV; nonzero only while laser_on=1.
REQ-013 busy  output  1  frame in progress (PREAMBLE..GUARD).
REQ-014 fault  output  1  sticky interlock fault flag.
REQ-015 frame_done  output  1  one-cycle pulse on frame completion.

Function
REQ-016 Frame = 14 symbols: preamble 1,0,1,0; 8 data bits MSB first; even-parity bit (XOR of the 8 data bits); guard symbol 0.
REQ-017 States: IDLE, PREAMBLE, DATA, PARITY, GUARD, FAULT.
REQ-018 tx_ready = 1 only in IDLE with interlock_ok=1 and rst_n=1.
REQ-019 Handshake: transfer occurs on an edge where tx_valid=1 and tx_ready=1; tx_data and drive_level are latched on that edge.
REQ-020 On transfer, the state goes to PREAMBLE and laser_on shows the first preamble symbol in the cycle immediately after the transfer edge (latency 1).
REQ-021 Each symbol holds for exactly CLKS_PER_BIT cycles via a bit-period counter; a symbol counter advances the state PREAMBLE(4) -> DATA(8) -> PARITY(1) -> GUARD(1) -> IDLE.
REQ-022 The frame occupies exactly 14*CLKS_PER_BIT cycles from the first preamble cycle to the last guard cycle.
REQ-023 frame_done pulses for one cycle: the first cycle back in IDLE.
REQ-024 tx_ready rises in that same cycle, so back-to-back frames are separated by exactly one IDLE cycle.
REQ-025 drive_code = min(latched drive_level, DRIVE_MAX_MV) when laser_on=1, else 0; the comparison is unsigned 16-bit.
REQ-026 A drive_level of 0 still sends the frame; laser_on toggles normally and drive_code stays 0.
REQ-027 busy = 1 in PREAMBLE, DATA, PARITY and GUARD; 0 in IDLE and FAULT.
REQ-028 interlock_ok=0 sampled in any busy state -> next edge enters FAULT; laser_on=0, drive_code=0, fault=1 from that edge; the frame is aborted and frame_done is not pulsed.
REQ-029 interlock_ok=0 in IDLE -> tx_ready=0 only; no fault raised.
REQ-030 FAULT -> IDLE only on an edge with fault_clr=1 and interlock_ok=1; fault clears on that edge.
REQ-031 fault_clr while interlock_ok=0, or outside FAULT, has no effect.
REQ-032 tx_valid is ignored while tx_ready=0; a held tx_valid is accepted on the first cycle tx_ready=1.

Reset
REQ-033 rst_n=0 on a clock edge forces IDLE and clears the bit counter, symbol counter and latched data/level.
REQ-034 Under reset: laser_on=0, drive_code=0, busy=0, fault=0, frame_done=0, tx_ready=0.
REQ-035 Reset mid-frame truncates the frame with no frame_done pulse.
REQ-036 The first cycle after rst_n returns to 1 is IDLE with tx_ready=interlock_ok.

Verification
REQ-037 CLKS_PER_BIT=4, send 0xA5 @ drive_level 3000 -> laser_on = 1010 10100101 0 0, each symbol 4 cycles, 56 cycles total; drive_code 3000 on 1-symbols, 0 otherwise; frame_done pulse at cycle 57.
REQ-038 Send 0x01 @ drive_level 6000 -> parity symbol 1; drive_code clipped to 4500 on every 1-symbol.
REQ-039 tx_valid held with 0x3C then 0xC3 -> two frames of 56 cycles each, one IDLE cycle between them (frame_done=tx_ready=1), second byte latched on that cycle.
REQ-040 interlock_ok dropped during DATA bit 3 -> next cycle fault=1, laser_on=0, drive_code=0, no frame_done; fault_clr with interlock_ok=0 is ignored; fault_clr with interlock_ok=1 -> IDLE, tx_ready=1.
REQ-041 rst_n=0 for one cycle during PARITY -> outputs match REQ-034 on that edge, no frame_done; a new frame is accepted after release.
REQ-042 CLKS_PER_BIT=1, send 0xFF -> 14-cycle frame, parity symbol 0.
